// File: rtl/xgmii_udp_rx_filter.sv
// xgmii_udp_rx_filter: parses Ethernet/IPv4/UDP headers on the 64-bit XGMII
// receive stream. Frames that match the local IP, the UDP port and the magic
// word have their payload beats written to the RX FIFO as {mask, data}.
// An aborted frame is closed with a {8'h00, all-ones} marker word.
// Optional build macro: RX_MAC_FILTER_EN also requires the destination MAC
// to equal if_macaddr or broadcast; without it the destination MAC is ignored.
//
// state | meaning
// IDLE  | between frames, waiting for SOF
// HDR   | checking header fields on beats 1..6
// PASS  | frame matched, writing beats 7.. to the FIFO
// DROP  | discarding the rest of the frame until terminate or idle
module xgmii_udp_rx_filter #(
   parameter logic [15:0] UDP_PORT  = 16'd3422,
   parameter logic [31:0] MAGIC     = 32'h4E554D41,
   parameter int          MAX_BEATS = 256,
   parameter int          CNT_W     = 32
) (
   input  logic             xgmii_clk,
   input  logic             sys_rst,
   input  logic [7:0]       xgmii_rxc,
   input  logic [63:0]      xgmii_rxd,
   input  logic [31:0]      if_v4addr,
   input  logic [47:0]      if_macaddr,
   output logic [71:0]      din,
   output logic             wr_en,
   input  logic             full,
   output logic [CNT_W-1:0] cnt_rx,
   output logic [CNT_W-1:0] cnt_match,
   output logic [CNT_W-1:0] cnt_drop,
   output logic [7:0]       led
);

   typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;

   // payload beat n sits at beat index n+6
   localparam logic [8:0]  LAST_BEAT  = 9'(MAX_BEATS + 6);
   localparam logic [71:0] ABORT_WORD = {8'h00, 64'hFFFF_FFFF_FFFF_FFFF};

   state_t          state_q, state_d;
   logic [8:0]      beat_q, beat_d, cur_idx;
   logic            abort_pend, pend_d;
   logic [7:0][7:0] lane;
   logic            sof, idle, is_term, is_err, over, field_ok, mac_ok;
   logic            frame_wr, marker_wr, abort;
   logic            inc_rx, inc_match, inc_drop;

   assign lane    = xgmii_rxd;
   assign sof     = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hFB);
   assign idle    = (xgmii_rxc == 8'hFF);
   // beat_q holds the index of the previous beat; the index saturates
   assign cur_idx = (&beat_q) ? beat_q : beat_q + 9'd1;
   assign over    = (cur_idx > LAST_BEAT);
   assign led     = cnt_match[7:0];

`ifdef RX_MAC_FILTER_EN
   logic [47:0] dst_mac;
   assign dst_mac = {lane[0], lane[1], lane[2], lane[3], lane[4], lane[5]};
   assign mac_ok  = (dst_mac == if_macaddr) || (&dst_mac);
`else
   logic unused_macaddr;
   assign unused_macaddr = ^if_macaddr;
   assign mac_ok         = 1'b1;
`endif

   // scan all lanes for terminate and error control characters
   always_comb begin
      is_term = 1'b0;
      is_err  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (xgmii_rxc[i] && (lane[i] == 8'hFD)) is_term = 1'b1;
         if (xgmii_rxc[i] && (lane[i] == 8'hFE)) is_err  = 1'b1;
      end
   end

   // header field that lives on the current beat (big-endian, lane 0 first)
   always_comb begin
      field_ok = 1'b1;
      case (cur_idx)
         9'd1:    field_ok = mac_ok;
         9'd2:    field_ok = ({lane[4], lane[5]} == 16'h0800) && (lane[6] == 8'h45);
         9'd3:    field_ok = (lane[7] == 8'h11);
         9'd4:    field_ok = ({lane[6], lane[7]} == if_v4addr[31:16]);
         9'd5:    field_ok = ({lane[0], lane[1]} == if_v4addr[15:0]) &&
                             ({lane[4], lane[5]} == UDP_PORT);
         9'd6:    field_ok = ({lane[2], lane[3], lane[4], lane[5]} == MAGIC);
         default: field_ok = 1'b1;
      endcase
   end

   // next state, frame writes, aborts and counter increments
   always_comb begin
      state_d   = state_q;
      beat_d    = cur_idx;
      frame_wr  = 1'b0;
      abort     = 1'b0;
      inc_rx    = 1'b0;
      inc_match = 1'b0;
      inc_drop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sof) begin
               state_d = HDR;
               beat_d  = 9'd0;
               inc_rx  = 1'b1;
            end
         end
         HDR: begin
            if (sof) begin
               beat_d = 9'd0;
               inc_rx = 1'b1;
            end else if (is_term || !field_ok) begin
               state_d = DROP;
            end else if (cur_idx == 9'd6) begin
               state_d   = PASS;
               inc_match = 1'b1;
            end
         end
         PASS: begin
            if (sof) begin
               abort   = 1'b1;
               state_d = HDR;
               beat_d  = 9'd0;
               inc_rx  = 1'b1;
            end else if (abort_pend) begin
               // previous frame's marker still queued: drop without a second one
               inc_drop = 1'b1;
               state_d  = DROP;
            end else if (is_err || over || full) begin
               abort   = 1'b1;
               state_d = DROP;
            end else begin
               frame_wr = 1'b1;
               if (is_term) state_d = IDLE;
            end
         end
         DROP: begin
            if (sof) begin
               state_d = HDR;
               beat_d  = 9'd0;
               inc_rx  = 1'b1;
            end else if (is_term || idle) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) inc_drop = 1'b1;
      marker_wr = abort_pend && !full && !frame_wr;
      pend_d    = abort || (abort_pend && !marker_wr);
   end

   // state, beat index and pending abort marker
   always_ff @(posedge xgmii_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         beat_q     <= 9'd0;
         abort_pend <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         abort_pend <= pend_d;
      end
   end

   // registered FIFO write, one cycle after the XGMII beat
   always_ff @(posedge xgmii_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_en <= 1'b0;
         din   <= '0;
      end else begin
         wr_en <= frame_wr || marker_wr;
         if (frame_wr)       din <= {~xgmii_rxc, xgmii_rxd};
         else if (marker_wr) din <= ABORT_WORD;
      end
   end

   // statistics counters, wrapping
   always_ff @(posedge xgmii_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_rx    <= '0;
         cnt_match <= '0;
         cnt_drop  <= '0;
      end else begin
         cnt_rx    <= cnt_rx    + CNT_W'(inc_rx);
         cnt_match <= cnt_match + CNT_W'(inc_match);
         cnt_drop  <= cnt_drop  + CNT_W'(inc_drop);
      end
   end

endmodule

// File: tb/tb_xgmii_udp_rx_filter.sv
// Testbench for xgmii_udp_rx_filter: frames are built as byte streams from
// header fields, the expected FIFO word stream and counters are derived from
// the filtering rules, and the captured FIFO writes are compared against them.
`timescale 1ns/1ps
module tb_xgmii_udp_rx_filter;

   localparam logic [15:0] UDP_PORT  = 16'd3422;
   localparam logic [31:0] MAGIC     = 32'h4E554D41;
   localparam int          MAX_BEATS = 256;
   localparam int          CNT_W     = 32;
   localparam logic [71:0] MARKER    = {8'h00, 64'hFFFF_FFFF_FFFF_FFFF};
   localparam logic [31:0] MY_IP     = 32'hC0A8_0A05;
   localparam logic [47:0] MY_MAC    = 48'h0200_0000_0042;

   logic             xgmii_clk = 1'b0;
   logic             sys_rst;
   logic [7:0]       xgmii_rxc;
   logic [63:0]      xgmii_rxd;
   logic [31:0]      if_v4addr;
   logic [47:0]      if_macaddr;
   logic [71:0]      din;
   logic             wr_en;
   logic             full;
   logic [CNT_W-1:0] cnt_rx, cnt_match, cnt_drop;
   logic [7:0]       led;

   xgmii_udp_rx_filter #(
      .UDP_PORT(UDP_PORT), .MAGIC(MAGIC), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
   ) dut (
      .xgmii_clk(xgmii_clk), .sys_rst(sys_rst),
      .xgmii_rxc(xgmii_rxc), .xgmii_rxd(xgmii_rxd),
      .if_v4addr(if_v4addr), .if_macaddr(if_macaddr),
      .din(din), .wr_en(wr_en), .full(full),
      .cnt_rx(cnt_rx), .cnt_match(cnt_match), .cnt_drop(cnt_drop), .led(led)
   );

   always #5 xgmii_clk = ~xgmii_clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [71:0] act_q[$];
   logic [71:0] exp_q[$];
   logic [7:0]  bc[$];
   logic [63:0] bd[$];
   bit          bf[$];
   int          exp_rx = 0, exp_match = 0, exp_drop = 0;
   bit          m_pend = 0, m_sof_abort = 0;

   always @(negedge xgmii_clk)
      if (!sys_rst && wr_en) act_q.push_back(din);

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] byte_at(input int k);
      logic [63:0] w;
      w = bd[k / 8];
      return w[8 * (k % 8) +: 8];
   endfunction

   function automatic bit has_ctrl(input int b, input logic [7:0] code);
      bit          r;
      logic [7:0]  c;
      logic [63:0] d;
      r = 1'b0;
      c = bc[b];
      d = bd[b];
      for (int i = 0; i < 8; i++)
         if (c[i] && d[8 * i +: 8] == code) r = 1'b1;
      return r;
   endfunction

   function automatic bit hdr_match();
      bit          ok;
      logic [47:0] dm;
      ok = ({byte_at(20), byte_at(21)} == 16'h0800) && (byte_at(22) == 8'h45) &&
           (byte_at(31) == 8'h11) &&
           ({byte_at(38), byte_at(39), byte_at(40), byte_at(41)} == if_v4addr) &&
           ({byte_at(44), byte_at(45)} == UDP_PORT) &&
           ({byte_at(50), byte_at(51), byte_at(52), byte_at(53)} == MAGIC);
      dm = {byte_at(8), byte_at(9), byte_at(10), byte_at(11), byte_at(12), byte_at(13)};
`ifdef RX_MAC_FILTER_EN
      ok = ok && ((dm == if_macaddr) || (dm == 48'hFFFF_FFFF_FFFF));
`else
      if (dm == 48'h0) ok = ok && 1'b1;
`endif
      return ok;
   endfunction

   // frame layout: beat b, lane i carries stream byte 8*b+i
   task automatic build_frame(input int corrupt, input int npay, input int tl,
                              input int full_at, input int full_len, input int fe_at,
                              input int mac_sel, input bit no_term, input int gap);
      logic [7:0]  hb[56];
      logic [47:0] dmac;
      logic [31:0] ip, mg;
      logic [15:0] port;
      logic [63:0] d;
      logic [7:0]  c, r;
      int          ln;
      ip   = if_v4addr;
      mg   = MAGIC;
      port = UDP_PORT;
      r    = 8'($urandom_range(1, 255));
      case (mac_sel)
         0:       dmac = if_macaddr;
         1:       dmac = 48'hFFFF_FFFF_FFFF;
         default: dmac = 48'h0200_0000_0099;
      endcase
      hb[0] = 8'hFB;
      for (int i = 1; i < 7; i++) hb[i] = 8'h55;
      hb[7] = 8'hD5;
      for (int i = 14; i < 56; i++) hb[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) hb[8 + i] = dmac[47 - 8 * i -: 8];
      hb[20] = 8'h08; hb[21] = 8'h00; hb[22] = 8'h45; hb[31] = 8'h11;
      for (int i = 0; i < 4; i++) hb[38 + i] = ip[31 - 8 * i -: 8];
      hb[44] = port[15:8]; hb[45] = port[7:0];
      for (int i = 0; i < 4; i++) hb[50 + i] = mg[31 - 8 * i -: 8];
      case (corrupt)
         1: hb[20] ^= r;
         2: hb[22] ^= r;
         3: hb[31] ^= r;
         4: hb[38 + $urandom_range(0, 1)] ^= r;
         5: hb[40 + $urandom_range(0, 1)] ^= r;
         6: hb[45] ^= 8'h01;
         7: hb[50 + $urandom_range(0, 3)] ^= r;
         default: ;
      endcase
      bc.delete(); bd.delete(); bf.delete();
      for (int b = 0; b < 7; b++) begin
         for (int i = 0; i < 8; i++) d[8 * i +: 8] = hb[8 * b + i];
         bc.push_back((b == 0) ? 8'h01 : 8'h00);
         bd.push_back(d);
      end
      for (int p = 0; p < npay; p++) begin
         d = {$urandom, $urandom};
         c = 8'h00;
         if (fe_at == 7 + p) begin
            ln = $urandom_range(0, 7);
            c[ln] = 1'b1;
            d[8 * ln +: 8] = 8'hFE;
         end
         bc.push_back(c);
         bd.push_back(d);
      end
      if (!no_term) begin
         for (int i = 0; i < 8; i++) begin
            if (i < tl)       begin c[i] = 1'b0; d[8 * i +: 8] = 8'($urandom); end
            else if (i == tl) begin c[i] = 1'b1; d[8 * i +: 8] = 8'hFD; end
            else              begin c[i] = 1'b1; d[8 * i +: 8] = 8'h07; end
         end
         bc.push_back(c);
         bd.push_back(d);
         for (int g = 0; g < gap; g++) begin
            bc.push_back(8'hFF);
            bd.push_back(64'h0707_0707_0707_0707);
         end
      end
      for (int b = 0; b < bc.size(); b++)
         bf.push_back((b >= full_at) && (b < full_at + full_len));
   endtask

   // expected outcome of the frame currently held in bc/bd/bf
   task automatic model_frame();
      int start;
      bit done;
      start = 0;
      exp_rx++;
      if (m_sof_abort) begin
         exp_drop++;
         exp_q.push_back(MARKER);
         m_pend      = 1'b1;
         m_sof_abort = 1'b0;
         start       = 1;
      end
      for (int b = start; b < 7; b++) if (!bf[b]) m_pend = 1'b0;
      if (!hdr_match()) begin
         for (int b = 7; b < bc.size(); b++) if (!bf[b]) m_pend = 1'b0;
         return;
      end
      exp_match++;
      done = 1'b0;
      for (int b = 7; b < bc.size(); b++) begin
         if (done) begin
            if (!bf[b]) m_pend = 1'b0;
         end else if (b == 7 && m_pend) begin
            exp_drop++;
            done = 1'b1;
            if (!bf[b]) m_pend = 1'b0;
         end else if ((b - 6 > MAX_BEATS) || has_ctrl(b, 8'hFE) || bf[b]) begin
            exp_drop++;
            exp_q.push_back(MARKER);
            m_pend = 1'b1;
            done   = 1'b1;
         end else begin
            exp_q.push_back({~bc[b], bd[b]});
            if (has_ctrl(b, 8'hFD)) done = 1'b1;
         end
      end
      if (!done) m_sof_abort = 1'b1;
   endtask

   task automatic drive_beat(input logic [7:0] c, input logic [63:0] d, input bit f);
      xgmii_rxc = c;
      xgmii_rxd = d;
      full      = f;
      @(posedge xgmii_clk);
      #1;
   endtask

   task automatic run_frame(input int corrupt, input int npay, input int tl,
                            input int full_at, input int full_len, input int fe_at,
                            input int mac_sel, input bit no_term, input int gap);
      build_frame(corrupt, npay, tl, full_at, full_len, fe_at, mac_sel, no_term, gap);
      model_frame();
      for (int b = 0; b < bc.size(); b++) drive_beat(bc[b], bd[b], bf[b]);
   endtask

   task automatic check_all(input string tag);
      int n;
      repeat (3) drive_beat(8'hFF, 64'h0707_0707_0707_0707, 1'b0);
      m_pend = 1'b0;
      check_eq({tag, " write count"}, 72'(act_q.size()), 72'(exp_q.size()));
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check_eq($sformatf("%s word %0d", tag, i), act_q[i], exp_q[i]);
      check_eq({tag, " cnt_rx"},    72'(cnt_rx),    72'(exp_rx));
      check_eq({tag, " cnt_match"}, 72'(cnt_match), 72'(exp_match));
      check_eq({tag, " cnt_drop"},  72'(cnt_drop),  72'(exp_drop));
      check_eq({tag, " led"},       72'(led),       72'(exp_match[7:0]));
      act_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int corrupt, npay, tl, fat, flen, fe, ms, gap;
      bit nt;
      sys_rst    = 1'b1;
      xgmii_rxc  = 8'hFF;
      xgmii_rxd  = 64'h0707_0707_0707_0707;
      full       = 1'b0;
      if_v4addr  = MY_IP;
      if_macaddr = MY_MAC;
      repeat (3) @(posedge xgmii_clk);
      #1;
      check_eq("reset wr_en",     72'(wr_en),     72'(0));
      check_eq("reset din",       din,            72'(0));
      check_eq("reset cnt_rx",    72'(cnt_rx),    72'(0));
      check_eq("reset cnt_match", 72'(cnt_match), 72'(0));
      check_eq("reset cnt_drop",  72'(cnt_drop),  72'(0));
      sys_rst = 1'b0;
      drive_beat(8'hFF, 64'h0707_0707_0707_0707, 1'b0);

      run_frame(0, 3, 4, -1, 0, -1, 0, 1'b0, 4);
      check_eq("good last mask", 72'(act_q[act_q.size() - 1][71:64]), 72'(8'h0F));
      check_all("good");
      run_frame(6, 3, 4, -1, 0, -1, 0, 1'b0, 4);
      check_all("dport 3423");
      run_frame(0, 6, 2, 8, 5, -1, 0, 1'b0, 4);
      check_all("full abort");
      run_frame(0, 300, 3, -1, 0, -1, 0, 1'b0, 4);
      check_all("oversize");
      run_frame(0, 2, 1, -1, 0, -1, 0, 1'b1, 0);
      run_frame(0, 2, 5, -1, 0, -1, 0, 1'b0, 4);
      check_all("sof in pass");
      run_frame(0, 3, 6, 8, 7, -1, 0, 1'b0, 4);
      run_frame(0, 3, 2, 0, 7, -1, 0, 1'b0, 4);
      check_all("pending marker");
      run_frame(0, 2, 0, -1, 0, 4, 0, 1'b0, 4);
      run_frame(0, 4, 7, -1, 0, 9, 0, 1'b0, 4);
      check_all("fe error");
      run_frame(0, 2, 3, -1, 0, -1, 2, 1'b0, 4);
      check_all("other mac");
      run_frame(0, 2, 3, -1, 0, -1, 1, 1'b0, 4);
      check_all("broadcast mac");

      // reset in the middle of a matched frame's payload
      build_frame(0, 10, 3, -1, 0, -1, 0, 1'b0, 4);
      for (int b = 0; b < 10; b++) drive_beat(bc[b], bd[b], bf[b]);
      sys_rst = 1'b1;
      #1;
      check_eq("midrst wr_en",     72'(wr_en),     72'(0));
      check_eq("midrst cnt_rx",    72'(cnt_rx),    72'(0));
      check_eq("midrst cnt_match", 72'(cnt_match), 72'(0));
      check_eq("midrst cnt_drop",  72'(cnt_drop),  72'(0));
      repeat (2) drive_beat(8'hFF, 64'h0707_0707_0707_0707, 1'b0);
      sys_rst = 1'b0;
      act_q.delete(); exp_q.delete();
      exp_rx = 0; exp_match = 0; exp_drop = 0; m_pend = 1'b0; m_sof_abort = 1'b0;
      drive_beat(8'hFF, 64'h0707_0707_0707_0707, 1'b0);
      run_frame(0, 5, 5, -1, 0, -1, 0, 1'b0, 4);
      check_all("after reset");

      for (int it = 0; it < 40; it++) begin
         corrupt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         npay    = $urandom_range(0, 12);
         tl      = $urandom_range(0, 7);
         fat     = -1; flen = 0; fe = -1;
         if ($urandom_range(0, 4) == 0) begin
            fat  = $urandom_range(7, 7 + npay);
            flen = $urandom_range(1, 3);
         end
         if (npay > 0 && $urandom_range(0, 5) == 0) fe = $urandom_range(7, 6 + npay);
         ms  = $urandom_range(0, 2);
         nt  = (it != 39) && ($urandom_range(0, 7) == 0);
         gap = $urandom_range(4, 6);
         run_frame(corrupt, npay, tl, fat, flen, fe, ms, nt, nt ? 0 : gap);
         if (!nt) check_all($sformatf("rand %0d", it));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
